// File: rtl/hazard_ctrl_param.sv
// Hazard and forwarding controller for a 5-stage ARM pipeline: operand forwarding, load-use and
// PC-write interlocks, variable-latency memory stalls with timeout, and stall/flush counters.
module hazard_ctrl_param #(
    parameter int unsigned REG_AW      = 4,
    parameter int unsigned NUM_SRC     = 3,
    parameter int unsigned PC_REG      = 15,
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_SRC*REG_AW-1:0] ra_d,
    input  logic [NUM_SRC*REG_AW-1:0] ra_e,
    input  logic [REG_AW-1:0]         rd_e,
    input  logic [REG_AW-1:0]         rd_m,
    input  logic [REG_AW-1:0]         rd_w,
    input  logic                      regwrite_e,
    input  logic                      regwrite_m,
    input  logic                      regwrite_w,
    input  logic                      memtoreg_e,
    input  logic                      memtoreg_m,
    input  logic                      mem_req_m,
    input  logic                      mem_ready,
    input  logic                      pcsrc_d,
    input  logic                      pcsrc_e,
    input  logic                      pcsrc_m,
    input  logic                      pcsrc_w,
    input  logic                      branch_taken_e,
    input  logic                      clr_cnt,
    output logic [NUM_SRC*2-1:0]      fwd_e,
    output logic                      stall_f,
    output logic                      stall_d,
    output logic                      stall_e,
    output logic                      stall_m,
    output logic                      flush_d,
    output logic                      flush_e,
    output logic                      flush_w,
    output logic                      mem_err,
    output logic [CNT_W-1:0]          stall_cnt,
    output logic [CNT_W-1:0]          flush_cnt
);

    localparam int unsigned        WCW       = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [REG_AW-1:0]  PC_ADDR   = REG_AW'(PC_REG);
    localparam logic [WCW-1:0]     WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StWait, StErr} state_e;

    state_e         state_q;
    logic [WCW-1:0] wait_cnt_q;
    logic           ldstall;
    logic           pcw;
    logic           mstall;
    logic           timeout;

    // M-stage ALU result wins over W; loads in M are not yet available for forwarding.
    always_comb begin
        fwd_e = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (reset && ra_e[i*REG_AW +: REG_AW] != PC_ADDR) begin
                if (regwrite_m && !memtoreg_m && rd_m == ra_e[i*REG_AW +: REG_AW]) begin
                    fwd_e[2*i +: 2] = 2'b10;
                end else if (regwrite_w && rd_w == ra_e[i*REG_AW +: REG_AW]) begin
                    fwd_e[2*i +: 2] = 2'b01;
                end
            end
        end
    end

    always_comb begin
        ldstall = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (ra_d[i*REG_AW +: REG_AW] != PC_ADDR && rd_e == ra_d[i*REG_AW +: REG_AW]) begin
                ldstall = ldstall | (memtoreg_e & regwrite_e);
            end
        end
    end

    assign pcw     = pcsrc_d | pcsrc_e | pcsrc_m;
    assign mstall  = mem_req_m & ~mem_ready;
    assign timeout = (state_q == StWait) && !mem_ready && (wait_cnt_q == WAIT_LAST);

    // A memory stall freezes everything; pending flushes are re-evaluated once released.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_w = 1'b0;
        if (!reset) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
            flush_w = 1'b1;
        end else if (mstall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
        end else begin
            stall_f = ldstall | pcw;
            stall_d = ldstall;
            flush_d = pcw | pcsrc_w | branch_taken_e;
            flush_e = ldstall | branch_taken_e;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            wait_cnt_q <= '0;
            mem_err    <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (mstall) begin
                        state_q    <= StWait;
                        wait_cnt_q <= WCW'(1);
                    end
                end
                StWait: begin
                    if (mem_ready) begin
                        state_q    <= StIdle;
                        wait_cnt_q <= '0;
                    end else if (timeout) begin
                        state_q    <= StErr;
                        wait_cnt_q <= '0;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                StErr: begin
                    if (mem_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q    <= StIdle;
                    wait_cnt_q <= '0;
                end
            endcase
            // Timeout set beats a simultaneous clear.
            if (timeout) begin
                mem_err <= 1'b1;
            end else if (clr_cnt) begin
                mem_err <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (clr_cnt) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_f && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if ((flush_d || flush_e) && flush_cnt != '1) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_param.sv
// Directed self-checking bench for hazard_ctrl_param with MEM_TIMEOUT=4 and 4-bit counters.
module tb_hazard_ctrl_param;

    localparam int unsigned REG_AW  = 4;
    localparam int unsigned NUM_SRC = 3;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NUM_SRC*REG_AW-1:0] ra_d, ra_e;
    logic [REG_AW-1:0]         rd_e, rd_m, rd_w;
    logic                      regwrite_e, regwrite_m, regwrite_w;
    logic                      memtoreg_e, memtoreg_m;
    logic                      mem_req_m, mem_ready;
    logic                      pcsrc_d, pcsrc_e, pcsrc_m, pcsrc_w;
    logic                      branch_taken_e, clr_cnt;
    logic [NUM_SRC*2-1:0]      fwd_e;
    logic                      stall_f, stall_d, stall_e, stall_m;
    logic                      flush_d, flush_e, flush_w;
    logic                      mem_err;
    logic [3:0]                stall_cnt, flush_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    hazard_ctrl_param #(
        .REG_AW     (REG_AW),
        .NUM_SRC    (NUM_SRC),
        .PC_REG     (15),
        .MEM_TIMEOUT(4),
        .CNT_W      (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ra_d          (ra_d),
        .ra_e          (ra_e),
        .rd_e          (rd_e),
        .rd_m          (rd_m),
        .rd_w          (rd_w),
        .regwrite_e    (regwrite_e),
        .regwrite_m    (regwrite_m),
        .regwrite_w    (regwrite_w),
        .memtoreg_e    (memtoreg_e),
        .memtoreg_m    (memtoreg_m),
        .mem_req_m     (mem_req_m),
        .mem_ready     (mem_ready),
        .pcsrc_d       (pcsrc_d),
        .pcsrc_e       (pcsrc_e),
        .pcsrc_m       (pcsrc_m),
        .pcsrc_w       (pcsrc_w),
        .branch_taken_e(branch_taken_e),
        .clr_cnt       (clr_cnt),
        .fwd_e         (fwd_e),
        .stall_f       (stall_f),
        .stall_d       (stall_d),
        .stall_e       (stall_e),
        .stall_m       (stall_m),
        .flush_d       (flush_d),
        .flush_e       (flush_e),
        .flush_w       (flush_w),
        .mem_err       (mem_err),
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ra_d = '0; ra_e = '0; rd_e = '0; rd_m = '0; rd_w = '0;
        regwrite_e = 0; regwrite_m = 0; regwrite_w = 0;
        memtoreg_e = 0; memtoreg_m = 0; mem_req_m = 0; mem_ready = 0;
        pcsrc_d = 0; pcsrc_e = 0; pcsrc_m = 0; pcsrc_w = 0;
        branch_taken_e = 0; clr_cnt = 0;
    endtask

    task automatic clear_counters();
        clr_cnt = 1;
        tick();
        clr_cnt = 0;
    endtask

    initial begin
        reset = 0;
        idle_inputs();
        #3;
        check("rst_stalls", {stall_f, stall_d, stall_e, stall_m}, 4'b0000);
        check("rst_flushes", {flush_d, flush_e, flush_w}, 3'b111);
        check("rst_fwd", fwd_e, 6'b0);
        check("rst_regs", {mem_err, stall_cnt, flush_cnt}, 9'b0);
        #9 reset = 1;
        #1;
        check("idle_flushes", {flush_d, flush_e, flush_w}, 3'b000);

        // Forwarding: op0 M-hit, op2 load in M falls back to W.
        ra_e = {4'd7, 4'd0, 4'd3}; rd_m = 3; regwrite_m = 1; rd_w = 3; regwrite_w = 1;
        #1 check("fwd_m_prio", fwd_e, 6'b00_00_10);
        regwrite_m = 0;
        #1 check("fwd_w", fwd_e, 6'b00_00_01);
        ra_e = {4'd7, 4'd0, 4'd15}; rd_m = 15; rd_w = 15; regwrite_m = 1;
        #1 check("fwd_pc", fwd_e, 6'b00_00_00);
        rd_m = 7; memtoreg_m = 1; rd_w = 7;
        #1 check("fwd_load_m", fwd_e, 6'b01_00_00);
        idle_inputs();

        // Load-use
        memtoreg_e = 1; regwrite_e = 1; rd_e = 5; ra_d = {4'd0, 4'd5, 4'd0};
        #1 check("lu_outs", {stall_f, stall_d, flush_e, flush_d}, 4'b1110);
        tick();
        memtoreg_e = 0; regwrite_e = 0;
        #1 check("lu_release", {stall_f, stall_d, flush_e}, 3'b000);
        check("lu_cnts", {stall_cnt, flush_cnt}, {4'd1, 4'd1});
        memtoreg_e = 1; regwrite_e = 1; rd_e = 15; ra_d = {4'd0, 4'd15, 4'd0};
        #1 check("lu_pc", {stall_f, stall_d}, 2'b00);
        tick();
        check("lu_pc_cnt", stall_cnt, 4'd1);
        idle_inputs();
        clear_counters();

        // Branch and PC-write sequence
        branch_taken_e = 1;
        #1 check("br_outs", {flush_d, flush_e, stall_f}, 3'b110);
        tick();
        branch_taken_e = 0;
        check("br_cnt", flush_cnt, 4'd1);
        for (int k = 0; k < 4; k++) begin
            {pcsrc_w, pcsrc_m, pcsrc_e, pcsrc_d} = 4'(1 << k);
            #1 check("pc_seq", {stall_f, flush_d}, {k < 3, 1'b1});
            tick();
        end
        idle_inputs();
        #1 check("pc_done", {stall_f, flush_d}, 2'b00);
        check("pc_cnts", {stall_cnt, flush_cnt}, {4'd3, 4'd5});
        clear_counters();

        // Zero-latency access
        mem_req_m = 1; mem_ready = 1;
        #1 check("mem_zero_lat", {stall_f, stall_m, flush_w}, 3'b000);
        tick();
        idle_inputs();

        // Memory wait with concurrent branch
        mem_req_m = 1; branch_taken_e = 1;
        for (int k = 0; k < 3; k++) begin
            #1 check("mw_stall", {stall_f, stall_d, stall_e, stall_m, flush_w}, 5'b11111);
            check("mw_noflush", {flush_d, flush_e}, 2'b00);
            tick();
        end
        mem_ready = 1;
        #1 check("mw_release", {stall_f, stall_m, flush_w, flush_d, flush_e}, 5'b00011);
        tick();
        idle_inputs();
        check("mw_cnts", {mem_err, stall_cnt, flush_cnt}, {1'b0, 4'd3, 4'd1});
        clear_counters();

        // Timeout: starts from IDLE, so mem_err appears after the 4th stall edge
        mem_req_m = 1;
        tick(); tick(); tick();
        check("to_not_yet", mem_err, 1'b0);
        tick();
        check("to_err", {mem_err, stall_f, stall_m}, 3'b111);
        tick();
        check("to_held", {mem_err, stall_f}, 2'b11);
        mem_ready = 1;
        #1 check("to_release", stall_f, 1'b0);
        tick();
        idle_inputs();
        check("to_sticky", {mem_err, stall_cnt}, {1'b1, 4'd5});
        clear_counters();
        check("to_clr", {mem_err, stall_cnt, flush_cnt}, 9'b0);

        // Timeout set beats simultaneous clear
        mem_req_m = 1;
        tick(); tick(); tick();
        clr_cnt = 1;
        tick();
        clr_cnt = 0;
        check("to_set_wins", {mem_err, stall_cnt}, {1'b1, 4'd0});
        mem_ready = 1;
        tick();
        idle_inputs();
        clear_counters();

        // Saturation
        pcsrc_d = 1;
        for (int k = 0; k < 15; k++) tick();
        check("sat_15", {stall_cnt, flush_cnt}, {4'd15, 4'd15});
        for (int k = 0; k < 5; k++) tick();
        check("sat_20", {stall_cnt, flush_cnt}, {4'd15, 4'd15});
        pcsrc_d = 0;

        // Reset asserted mid-WAIT, between clock edges
        mem_req_m = 1;
        tick(); tick();
        #2 reset = 0;
        #1 check("arst_stalls", {stall_f, stall_d, stall_e, stall_m}, 4'b0000);
        check("arst_flushes", {flush_d, flush_e, flush_w}, 3'b111);
        check("arst_regs", {mem_err, stall_cnt, flush_cnt}, 9'b0);
        idle_inputs();
        tick();
        reset = 1;
        // Back in IDLE: a fresh wait must take 4 edges to time out
        mem_req_m = 1;
        tick(); tick(); tick();
        check("arst_idle", mem_err, 1'b0);
        tick();
        check("arst_to", mem_err, 1'b1);
        idle_inputs();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_param.md
Name: hazard_ctrl_param

Overview:
Parametrised hazard and forwarding controller for the 5-stage pipelined ARM datapath (F/D/E/M/W).
- Generates the per-operand forwarding selects for Execute.
- Generates load-use stalls, PC-write/branch flushes, and whole-pipeline stalls for a data memory with variable latency (ready handshake).
- Adds a memory-wait FSM with timeout, a sticky error flag, and saturating stall/flush performance counters.

Parameters:
REG_AW, 4, register address width
NUM_SRC, 3, number of Execute source operands tracked (Rn, Rm, Rs)
PC_REG, 15, register index never forwarded or hazard-checked
MEM_TIMEOUT, 64, memory-wait cycles before mem_err is raised (>=2)
CNT_W, 16, performance counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
ra_d  in  NUM_SRC*REG_AW  Decode source register addresses; operand i is bits [i*REG_AW +: REG_AW]
ra_e  in  NUM_SRC*REG_AW  Execute source register addresses
rd_e, rd_m, rd_w  in  REG_AW each  destination registers in E/M/W
regwrite_e, regwrite_m, regwrite_w  in  1 each  register write enables per stage
memtoreg_e, memtoreg_m  in  1 each  load in E/M
mem_req_m  in  1  M-stage instruction accesses data memory
mem_ready  in  1  data memory completes the access this cycle
pcsrc_d, pcsrc_e, pcsrc_m, pcsrc_w  in  1 each  PC-writing instruction in stage
branch_taken_e  in  1  branch resolved taken in E
clr_cnt  in  1  synchronous clear of counters and mem_err
fwd_e  out  NUM_SRC*2  per operand: 00 regfile, 01 ResultW, 10 ALUResultM
stall_f, stall_d, stall_e, stall_m  out  1 each  hold pipeline register
flush_d, flush_e, flush_w  out  1 each  insert bubble
mem_err  out  1  sticky memory timeout flag
stall_cnt  out  CNT_W  cycles with stall_f=1
flush_cnt  out  CNT_W  cycles with flush_d|flush_e=1

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, wait_cnt=0, mem_err=0, both counters 0.
  - While reset=0: all stalls 0; flush_d, flush_e, flush_w =1; fwd_e all 00.
- Forwarding (combinational), per operand i:
  - 10 if regwrite_m & ~memtoreg_m & rd_m==ra_e[i];
  - else 01 if regwrite_w & rd_w==ra_e[i];
  - else 00.
  - M has priority over W.
  - ra_e[i]==PC_REG always gives 00.
- Load-use (combinational): ldstall = memtoreg_e & regwrite_e & (rd_e==ra_d[i] for any i with ra_d[i]!=PC_REG).
- PC pending: pcw = pcsrc_d|pcsrc_e|pcsrc_m.
- Memory stall: mstall = mem_req_m & ~mem_ready, independent of FSM state.
- Output equations when mstall=0:
  - stall_f = ldstall|pcw
  - stall_d = ldstall
  - stall_e = stall_m = 0
  - flush_d = pcw|pcsrc_w|branch_taken_e
  - flush_e = ldstall|branch_taken_e
  - flush_w = 0
- Output equations when mstall=1 (overrides all of the above):
  - stall_f = stall_d = stall_e = stall_m = 1
  - flush_d = flush_e = 0; the frozen branch/load condition re-evaluates after release
  - flush_w = 1
- FSM (registered), states IDLE, WAIT, ERR:
  - IDLE -> WAIT when mstall; wait_cnt <= 1.
  - WAIT -> IDLE when mem_ready; wait_cnt <= 0.
  - WAIT -> ERR when mem_ready=0 and wait_cnt==MEM_TIMEOUT-1; set mem_err.
  - Otherwise in WAIT, wait_cnt increments.
  - ERR -> IDLE when mem_ready. The pipeline stays stalled in ERR by mstall alone.
  - A zero-latency access (mem_req_m & mem_ready in the same cycle) never leaves IDLE and causes no stall.
  - Back-to-back accesses: WAIT->IDLE on ready. The next M instruction re-enters WAIT the following cycle if not ready.
- mem_err:
  - Sticky until clr_cnt or reset.
  - If clr_cnt and the timeout occur in the same cycle, the set wins.
- Counters:
  - Each counter increments by 1 on its condition.
  - Each saturates at all-ones; no wrap.
  - clr_cnt sets the counter to 0 and takes priority over increment in the same cycle.
- Reset asserted mid-WAIT returns immediately to IDLE with counters cleared.

Test Plan:
- Forwarding, ra_e op0=3, rd_m=3 regwrite_m=1 memtoreg_m=0, and rd_w=3 regwrite_w=1 -> fwd_e[1:0]=10. Drop regwrite_m -> 01. Set ra_e op0=15 -> 00.
- Load-use: memtoreg_e=1 regwrite_e=1 rd_e=5, ra_d op1=5 -> stall_f=stall_d=flush_e=1 for exactly 1 cycle, stall_cnt=1. Same with rd_e=15 -> no stall.
- Branch: branch_taken_e=1 -> flush_d=flush_e=1, flush_cnt increments. pcsrc_d then e then m over 3 cycles -> stall_f=1 for 3 cycles, flush_d=1 for 4 cycles including pcsrc_w.
- Memory wait: mem_req_m=1, mem_ready=0 for 3 cycles then 1 -> stall_f/d/e/m and flush_w =1 for 3 cycles. FSM IDLE->WAIT->IDLE. A concurrent branch_taken_e gives flush_d=0 while stalled, then 1 after release.
- Timeout: MEM_TIMEOUT=4, mem_ready held 0 -> mem_err=1 on the 4th stall cycle, pipeline stays stalled. mem_ready=1 -> release, mem_err stays 1. clr_cnt -> mem_err=0, counters 0.
- Saturation/reset: CNT_W=4, stall 20 cycles -> stall_cnt=15. Assert reset mid-WAIT -> all counters 0, stalls 0, flush_d/e/w=1 asynchronously.
